// File: rtl/mac32_pkg.sv
`default_nettype none
// =============================================================================
// mac32_pkg : shared types, constants and helpers for the mac32 FMA core.
// Revision  : 1.0
// =============================================================================
package mac32_pkg;

   localparam int PARM_XLEN_DEF = 32;
   localparam int PARM_EXP_DEF  = 8;
   localparam int PARM_MANT_DEF = 23;
   localparam int PARM_BIAS_DEF = 127;

   localparam int MUL_CYCLES = 24;
   localparam int DP_W       = 76;

   localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF    = 32'h7F80_0000;
   localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE, ST_UNPACK, ST_MUL, ST_ALIGN, ST_ADD, ST_NORM, ST_PACK, ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN
   } fclass_t;

   typedef struct packed {
      logic                     sign;
      logic [PARM_EXP_DEF-1:0]  exp;
      logic [PARM_MANT_DEF-1:0] mant;
   } fp32_t;

   // Subnormals classify as zero so they are flushed before entering the datapath.
   function automatic fclass_t classify(input fp32_t f);
      fclass_t cls;
      if (f.exp == '0)      cls = CLS_ZERO;
      else if (f.exp == '1) cls = (f.mant == '0) ? CLS_INF : CLS_NAN;
      else                  cls = CLS_NORM;
      return cls;
   endfunction

   function automatic logic [PARM_MANT_DEF:0] signif(input fp32_t f);
      return (classify(f) == CLS_NORM) ? {1'b1, f.mant} : '0;
   endfunction

   // Right shift that ORs every bit shifted out into bit 0 (sticky jam).
   function automatic logic [DP_W-1:0] shr_sticky(input logic [DP_W-1:0] x,
                                                   input logic [11:0]     sh);
      logic [DP_W-1:0] mask;
      logic [DP_W-1:0] y;
      if (sh >= 12'(DP_W)) begin
         y    = '0;
         y[0] = |x;
      end else begin
         mask = (DP_W'(1) << sh[6:0]) - DP_W'(1);
         y    = x >> sh[6:0];
         y[0] = y[0] | (|(x & mask));
      end
      return y;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac32_mul_iter.sv
`default_nettype none
// =============================================================================
// mac32_mul_iter : 24x24 shift-add multiplier, one multiplier bit per cycle.
// Revision       : 1.0
// =============================================================================
module mac32_mul_iter
   import mac32_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_ni,
   input  logic                    i_start,
   input  logic [MUL_CYCLES-1:0]   i_mcand,
   input  logic [MUL_CYCLES-1:0]   i_mplier,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [2*MUL_CYCLES-1:0] o_product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);

   logic [2*MUL_CYCLES-1:0] r_mcand;
   logic [2*MUL_CYCLES-1:0] r_acc;
   logic [MUL_CYCLES-1:0]   r_mplier;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_busy;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= {{MUL_CYCLES{1'b0}}, i_mcand};
         r_acc    <= '0;
         r_mplier <= i_mplier;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (r_cnt == CNT_W'(MUL_CYCLES - 1)) r_busy <= 1'b0;
      end
   end

   // Done flags the final iteration; the product is complete after that edge.
   assign o_done    = r_busy && (r_cnt == CNT_W'(MUL_CYCLES - 1));
   assign o_busy    = r_busy;
   assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/mac32_seq_core.sv
`default_nettype none
// =============================================================================
// mac32_seq_core : multi-cycle binary32 fused multiply-add, Result = A + B*C.
// Build option ROUND_RNE_EN: nearest-even with overflow to Inf; otherwise
// truncation with overflow to max finite.
// Revision       : 1.0
// =============================================================================
module mac32_seq_core #(
   parameter int PARM_XLEN = mac32_pkg::PARM_XLEN_DEF,
   parameter int PARM_EXP  = mac32_pkg::PARM_EXP_DEF,
   parameter int PARM_MANT = mac32_pkg::PARM_MANT_DEF,
   parameter int PARM_BIAS = mac32_pkg::PARM_BIAS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [PARM_XLEN-1:0] A_i,
   input  logic [PARM_XLEN-1:0] B_i,
   input  logic [PARM_XLEN-1:0] C_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [PARM_XLEN-1:0] Result_o
);
   import mac32_pkg::*;

   localparam int EXP_MAX = (1 << PARM_EXP) - 1;
`ifdef ROUND_RNE_EN
   localparam bit RND_RNE = 1'b1;
`else
   localparam bit RND_RNE = 1'b0;
`endif

   state_t r_state, w_state_nxt;

   logic [PARM_XLEN-1:0] r_a_raw, r_b_raw, r_c_raw;
   fp32_t                w_fa, w_fb, w_fc;
   fclass_t              r_cls_a, r_cls_b, r_cls_c;
   logic                 r_sa, r_sp;
   logic [7:0]           r_ea;
   logic signed [9:0]    r_ep;
   logic [PARM_MANT:0]   r_siga, r_sigb, r_sigc;

   logic                 w_mul_start, w_mul_busy, w_mul_done;
   logic [47:0]          w_prod;

   logic [DP_W-1:0]      r_al_a, r_al_p, w_al_a, w_al_p, w_aword, w_pword;
   logic signed [11:0]   r_ebig, w_ebig, w_ea_s, w_ep_s;
   logic [11:0]          w_diff;

   logic [DP_W-1:0]      r_sum, w_sum;
   logic                 r_ssum, w_ssum;

   logic [6:0]           w_lead, w_nshift;
   logic [DP_W-1:0]      r_norm;
   logic signed [11:0]   r_exp_n, w_exp_r;
   logic                 r_zero;

   logic                 w_guard, w_round, w_sticky, w_inc;
   logic [24:0]          w_mant25;
   logic [22:0]          w_frac;
   logic [31:0]          w_num, w_pack, r_result;
   logic                 w_any_nan, w_inf_zero, w_a_inf, w_p_inf;

   assign w_fa = r_a_raw;
   assign w_fb = r_b_raw;
   assign w_fc = r_c_raw;

   mac32_mul_iter u_mul (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .i_start   (w_mul_start),
      .i_mcand   (r_sigb),
      .i_mplier  (r_sigc),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_prod)
   );

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      w_mul_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) w_state_nxt = ST_UNPACK;
         end
         ST_UNPACK: w_state_nxt = ST_MUL;
         ST_MUL: begin
            w_mul_start = !w_mul_busy;
            if (w_mul_done) w_state_nxt = ST_ALIGN;
         end
         ST_ALIGN: w_state_nxt = ST_ADD;
         ST_ADD:   w_state_nxt = ST_NORM;
         ST_NORM:  w_state_nxt = ST_PACK;
         ST_PACK:  w_state_nxt = ST_DONE;
         ST_DONE: begin
            valid_o = 1'b1;
            if (ready_i) w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Both 48-bit words share one scale; bit 75 is carry headroom, bits 26:0 alignment room.
   always_comb begin
      w_ea_s  = $signed({4'b0, r_ea});
      w_ep_s  = {{2{r_ep[9]}}, r_ep};
      w_aword = {2'b0, r_siga, 50'b0};
      w_pword = {1'b0, w_prod, 27'b0};
      w_al_a  = w_aword;
      w_al_p  = w_pword;
      w_ebig  = w_ea_s;
      w_diff  = '0;
      if (w_prod == '0) begin
         w_ebig = w_ea_s;
      end else if (r_siga == '0) begin
         w_ebig = w_ep_s;
      end else if (w_ep_s >= w_ea_s) begin
         w_ebig = w_ep_s;
         w_diff = w_ep_s - w_ea_s;
         w_al_a = shr_sticky(w_aword, w_diff);
      end else begin
         w_ebig = w_ea_s;
         w_diff = w_ea_s - w_ep_s;
         w_al_p = shr_sticky(w_pword, w_diff);
      end
   end

   always_comb begin
      w_sum  = r_al_a + r_al_p;
      w_ssum = r_sa;
      if (r_sa != r_sp) begin
         if (r_al_a >= r_al_p) begin
            w_sum  = r_al_a - r_al_p;
            w_ssum = r_sa;
         end else begin
            w_sum  = r_al_p - r_al_a;
            w_ssum = r_sp;
         end
      end
   end

   always_comb begin
      w_lead = '0;
      for (int i = 0; i < DP_W; i++) begin
         if (r_sum[i]) w_lead = 7'(i);
      end
      w_nshift = 7'(DP_W - 1) - w_lead;
   end

   always_comb begin
      w_guard  = r_norm[51];
      w_round  = r_norm[50];
      w_sticky = |r_norm[49:0];
      w_inc    = RND_RNE & w_guard & (w_round | w_sticky | r_norm[52]);
      w_mant25 = {1'b0, r_norm[75:52]} + 25'(w_inc);
      w_frac   = w_mant25[24] ? w_mant25[23:1] : w_mant25[22:0];
      w_exp_r  = w_mant25[24] ? (r_exp_n + 12'sd1) : r_exp_n;
      if (w_exp_r < 12'sd1)
         w_num = {r_ssum, 31'b0};
      else if (w_exp_r >= $signed(12'(EXP_MAX)))
         w_num = {r_ssum, (RND_RNE ? POS_INF[30:0] : MAX_FINITE[30:0])};
      else
         w_num = {r_ssum, w_exp_r[7:0], w_frac};
   end

   always_comb begin
      w_any_nan  = (r_cls_a == CLS_NAN) || (r_cls_b == CLS_NAN) || (r_cls_c == CLS_NAN);
      w_inf_zero = ((r_cls_b == CLS_INF) && (r_cls_c == CLS_ZERO)) ||
                   ((r_cls_c == CLS_INF) && (r_cls_b == CLS_ZERO));
      w_a_inf    = (r_cls_a == CLS_INF);
      w_p_inf    = ((r_cls_b == CLS_INF) || (r_cls_c == CLS_INF)) && !w_inf_zero;
      if (w_any_nan || w_inf_zero)               w_pack = CANON_NAN;
      else if (w_a_inf && w_p_inf && (r_sa != r_sp)) w_pack = CANON_NAN;
      else if (w_a_inf)                          w_pack = {r_sa, POS_INF[30:0]};
      else if (w_p_inf)                          w_pack = {r_sp, POS_INF[30:0]};
      else if (r_zero)                           w_pack = {r_sa & r_sp, 31'b0};
      else                                       w_pack = w_num;
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a_raw  <= '0;
         r_b_raw  <= '0;
         r_c_raw  <= '0;
         r_cls_a  <= CLS_ZERO;
         r_cls_b  <= CLS_ZERO;
         r_cls_c  <= CLS_ZERO;
         r_sa     <= 1'b0;
         r_sp     <= 1'b0;
         r_ea     <= '0;
         r_ep     <= '0;
         r_siga   <= '0;
         r_sigb   <= '0;
         r_sigc   <= '0;
         r_al_a   <= '0;
         r_al_p   <= '0;
         r_ebig   <= '0;
         r_sum    <= '0;
         r_ssum   <= 1'b0;
         r_norm   <= '0;
         r_exp_n  <= '0;
         r_zero   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i) begin
                  r_a_raw <= A_i;
                  r_b_raw <= B_i;
                  r_c_raw <= C_i;
               end
            end
            ST_UNPACK: begin
               r_cls_a <= classify(w_fa);
               r_cls_b <= classify(w_fb);
               r_cls_c <= classify(w_fc);
               r_sa    <= w_fa.sign;
               r_sp    <= w_fb.sign ^ w_fc.sign;
               r_ea    <= w_fa.exp;
               r_ep    <= $signed({2'b0, w_fb.exp} + {2'b0, w_fc.exp} - 10'(PARM_BIAS));
               r_siga  <= signif(w_fa);
               r_sigb  <= signif(w_fb);
               r_sigc  <= signif(w_fc);
            end
            ST_ALIGN: begin
               r_al_a <= w_al_a;
               r_al_p <= w_al_p;
               r_ebig <= w_ebig;
            end
            ST_ADD: begin
               r_sum  <= w_sum;
               r_ssum <= w_ssum;
            end
            ST_NORM: begin
               r_norm  <= r_sum << w_nshift;
               r_exp_n <= r_ebig + $signed({5'b0, w_lead}) - 12'sd73;
               r_zero  <= (r_sum == '0);
            end
            ST_PACK:  r_result <= w_pack;
            default: ;
         endcase
      end
   end

   assign Result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mac32_seq_core.sv
`default_nettype none
// =============================================================================
// tb_mac32_seq_core : directed-vector bench for mac32_seq_core.
// Revision          : 1.0
// =============================================================================
module tb_mac32_seq_core;

`ifdef ROUND_RNE_EN
   localparam logic [31:0] EXP_RND  = 32'h3F80_0001;
   localparam logic [31:0] EXP_OVF  = 32'h7F80_0000;
   localparam logic [31:0] EXP_CANC = 32'h3F80_0000;
`else
   localparam logic [31:0] EXP_RND  = 32'h3F80_0000;
   localparam logic [31:0] EXP_OVF  = 32'h7F7F_FFFF;
   localparam logic [31:0] EXP_CANC = 32'h3F7F_FFFF;
`endif

   logic        clk;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] A_i, B_i, C_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] Result_o;

   int n_cmp = 0;
   int n_err = 0;

   mac32_seq_core dut (
      .clk      (clk),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .A_i      (A_i),
      .B_i      (B_i),
      .C_i      (C_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .Result_o (Result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] want, input int bp);
      int lat;
      int w;
      bit seen;
      @(negedge clk);
      w = 0;
      while (!ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_rdy"}, 32'(ready_o), 32'd1);
      A_i = a; B_i = b; C_i = c; valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      A_i = $urandom; B_i = $urandom; C_i = $urandom;
      check({tag, "_busy"}, 32'(ready_o), 32'd0);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (valid_o) seen = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'd30);
      check({tag, "_res"}, Result_o, want);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         A_i     = ~A_i;
         valid_i = ~valid_i;
         @(posedge clk);
         #1;
         check({tag, "_bp_res"}, Result_o, want);
         check({tag, "_bp_vld"}, 32'(valid_o), 32'd1);
         check({tag, "_bp_rdy"}, 32'(ready_o), 32'd0);
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check({tag, "_hs_vld"}, 32'(valid_o), 32'd0);
      check({tag, "_hs_rdy"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      A_i = '0; B_i = '0; C_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", 32'(ready_o), 32'd1);
      check("rst_vld", 32'(valid_o), 32'd0);
      check("rst_res", Result_o, 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      run_op("basic",   32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40E0_0000, 0);
      run_op("cancel",  32'hC0C0_0000, 32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 0);
      run_op("nan_a",   32'h7FC0_0000, 32'h4000_0000, 32'h4040_0000, 32'h7FC0_0000, 0);
      run_op("inf_x0",  32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
      run_op("inf_inf", 32'hFF80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0);
      run_op("inf_p",   32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 0);
      run_op("round",   32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000, EXP_RND,       0);
      run_op("ovf",     32'h0000_0000, 32'h7F00_0000, 32'h7F00_0000, EXP_OVF,       0);
      run_op("negzero", 32'h8000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 0);
      run_op("undf",    32'h0000_0000, 32'h9F80_0000, 32'h1F80_0000, 32'h8000_0000, 0);
      run_op("subrnd",  32'h3F80_0000, 32'hBF80_0000, 32'h3300_0000, EXP_CANC,      0);
      run_op("bpress",  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40E0_0000, 10);

      @(negedge clk);
      A_i = 32'h3F80_0000; B_i = 32'h4000_0000; C_i = 32'h4040_0000; valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_ni = 1'b0;
      #1;
      check("midrst_vld", 32'(valid_o), 32'd0);
      check("midrst_rdy", 32'(ready_o), 32'd1);
      check("midrst_res", Result_o, 32'h0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      run_op("post_rst", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40E0_0000, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
